calc_op_sequencer: RTL and testbench

- Sequences one calculator operation after the key decoder grants a command: serially loads the opcode and two operands, starts the ALU, waits for completion, then shifts the result out serially.
- Sits between the input-key decoder (consumes its active/mode outputs) and the ALU datapath (drives opcode/operands/start, receives result/done).
- Single clock domain. Reset is synchronous and active-high.

---
 rtl/calc_op_sequencer.sv | 159 +++++++++++++++
 tb/tb_calc_op_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// Serially loads opcode and operands, starts the ALU and waits for it (bounded by TIMEOUT), then shifts the result out.
// Start edge to first out_valid: OPW+2*WIDTH+N+2 cycles; valid_data gaps stall loading, output has no backpressure.
module calc_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int OPW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             mode,
  input  logic             valid_data,
  input  logic             data_bit,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [OPW-1:0]   op_code,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             alu_start,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_OP, S_LOAD_A, S_LOAD_B, S_EXEC, S_WAIT, S_OUT, S_DONE
  } state_t;

  localparam int LW = (WIDTH > OPW) ? WIDTH : OPW;
  localparam int CW = $clog2(LW + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state, state_n;
  logic           active_q;
  logic           mode_q;
  logic [CW-1:0]  cnt;
  logic [TW-1:0]  tcnt;
  logic [WIDTH-1:0] res_q;
  logic           start;
  logic           load_last;
  logic           out_last;
  logic           wait_timeout;
  logic [CW-1:0]  out_idx;
  logic           out_sel;

  assign start        = active & ~active_q & (state == S_IDLE);
  assign load_last    = (state == S_LOAD_OP) ? (cnt == CW'(OPW - 1)) : (cnt == CW'(WIDTH - 1));
  assign out_last     = (cnt == CW'(WIDTH - 1));
  assign wait_timeout = (tcnt == TW'(TIMEOUT - 1));
  assign out_idx      = mode_q ? cnt : (CW'(WIDTH - 1) - cnt);
  assign out_sel      = |(res_q & (WIDTH'(1) << out_idx));
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    alu_start = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:    if (start) state_n = S_LOAD_OP;
      S_LOAD_OP: if (valid_data && load_last) state_n = S_LOAD_A;
      S_LOAD_A:  if (valid_data && load_last) state_n = S_LOAD_B;
      S_LOAD_B:  if (valid_data && load_last) state_n = S_EXEC;
      S_EXEC: begin
        alu_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done)          state_n = S_OUT;
        else if (wait_timeout) state_n = S_DONE;
      end
      S_OUT:     if (out_last) state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      tcnt      <= '0;
      res_q     <= '0;
      op_code   <= '0;
      operand_a <= '0;
      operand_b <= '0;
      error     <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      active_q  <= active;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            op_code   <= '0;
            operand_a <= '0;
            operand_b <= '0;
            error     <= 1'b0;
            cnt       <= '0;
          end
        end
        // LSB-first writes the bit at position cnt; MSB-first shifts it in at the bottom
        S_LOAD_OP: begin
          if (valid_data) begin
            op_code <= mode_q ? ((op_code & ~(OPW'(1) << cnt)) | (OPW'(data_bit) << cnt))
                              : ((op_code << 1) | OPW'(data_bit));
            cnt     <= load_last ? '0 : cnt + 1'b1;
          end
        end
        S_LOAD_A: begin
          if (valid_data) begin
            operand_a <= mode_q ? ((operand_a & ~(WIDTH'(1) << cnt)) | (WIDTH'(data_bit) << cnt))
                                : ((operand_a << 1) | WIDTH'(data_bit));
            cnt       <= load_last ? '0 : cnt + 1'b1;
          end
        end
        S_LOAD_B: begin
          if (valid_data) begin
            operand_b <= mode_q ? ((operand_b & ~(WIDTH'(1) << cnt)) | (WIDTH'(data_bit) << cnt))
                                : ((operand_b << 1) | WIDTH'(data_bit));
            cnt       <= load_last ? '0 : cnt + 1'b1;
          end
        end
        S_EXEC: tcnt <= '0;
        S_WAIT: begin
          if (alu_done) begin
            res_q <= alu_result;
            cnt   <= '0;
          end else if (wait_timeout) begin
            error <= 1'b1;
            res_q <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_OUT: begin
          out_valid <= 1'b1;
          out_bit   <= out_sel;
          cnt       <= out_last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomized scoreboard bench for calc_op_sequencer: driver pushes expectations, a negedge monitor pops and compares.
module tb_calc_op_sequencer;

  localparam int W   = 4;
  localparam int OPW = 2;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           active = 1'b0;
  logic           mode = 1'b0;
  logic           valid_data = 1'b0;
  logic           data_bit = 1'b0;
  logic           alu_done = 1'b0;
  logic [W-1:0]   alu_result = '0;
  logic [OPW-1:0] op_code;
  logic [W-1:0]   operand_a;
  logic [W-1:0]   operand_b;
  logic           alu_start;
  logic           out_bit;
  logic           out_valid;
  logic           busy;
  logic           done;
  logic           error;

  calc_op_sequencer #(.WIDTH(W), .OPW(OPW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .mode       (mode),
    .valid_data (valid_data),
    .data_bit   (data_bit),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .op_code    (op_code),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_start  (alu_start),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } exec_t;

  typedef struct {
    bit err;
    int nbits;
  } done_t;

  exec_t exec_q[$];
  bit    bit_q[$];
  done_t done_q[$];
  exec_t cur;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_ov_cyc = 0;
  int bits_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic maybe_toggle(input bit t);
    if (t && busy) active = 1'($urandom_range(0, 1));
  endtask

  // Monitor: compares DUT outputs against the expectations queued by the driver.
  initial begin
    exec_t e;
    done_t d;
    bit    b;
    forever begin
      @(negedge clk);
      if (alu_start) begin
        check("alu_start_expected", exec_q.size() != 0, 1);
        if (exec_q.size() != 0) begin
          e = exec_q.pop_front();
          cur = e;
          check("op_code", op_code, e.op);
          check("operand_a", operand_a, e.a);
          check("operand_b", operand_b, e.b);
        end
      end
      if (out_valid) begin
        if (bits_seen == 0) first_ov_cyc = cyc;
        bits_seen++;
        check("out_bit_expected", bit_q.size() != 0, 1);
        if (bit_q.size() != 0) begin
          b = bit_q.pop_front();
          check("out_bit", out_bit, b);
        end
      end else begin
        check("out_bit_idle_zero", out_bit, 0);
      end
      if (done) begin
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("error_at_done", error, d.err);
          check("out_bit_count", bits_seen, d.nbits);
          check("operands_stable", {op_code, operand_a, operand_b}, {cur.op, cur.a, cur.b});
        end
        bits_seen = 0;
      end
    end
  end

  // n: alu_done asserted n cycles after alu_start; 0 = never, -1 = only in the EXEC cycle.
  task automatic run_txn(input bit md, input logic [OPW-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int gap, input int n,
                         input logic [W-1:0] res, input bit tgl);
    bit    s[$];
    exec_t e;
    done_t d;
    bit    err;
    int    st;
    int    k;
    err = !(n >= 1 && n <= TO);
    for (int i = 0; i < OPW; i++) s.push_back(md ? op[i] : op[OPW-1-i]);
    for (int i = 0; i < W; i++)   s.push_back(md ? a[i] : a[W-1-i]);
    for (int i = 0; i < W; i++)   s.push_back(md ? b[i] : b[W-1-i]);
    e.op = op; e.a = a; e.b = b;
    exec_q.push_back(e);
    if (!err) for (int i = 0; i < W; i++) bit_q.push_back(md ? res[i] : res[W-1-i]);
    d.err = err;
    d.nbits = err ? 0 : W;
    done_q.push_back(d);

    active = 1'b0; mode = md; tick();
    active = 1'b1; tick();
    st = cyc;
    mode = 1'($urandom_range(0, 1));
    check("busy_after_start", busy, 1);
    check("error_cleared_on_start", error, 0);

    foreach (s[i]) begin
      repeat (gap) begin
        valid_data = 1'b0; data_bit = 1'($urandom_range(0, 1)); maybe_toggle(tgl); tick();
      end
      valid_data = 1'b1; data_bit = s[i]; maybe_toggle(tgl); tick();
    end
    valid_data = 1'b0;
    data_bit = 1'b0;
    check("alu_start_after_last_bit", alu_start, 1);

    if (n == -1) begin
      alu_done = 1'b1; alu_result = res; tick();
      alu_done = 1'b0;
    end else if (n >= 1) begin
      repeat (n) begin
        if (n <= TO) maybe_toggle(tgl);
        tick();
      end
      alu_done = 1'b1; alu_result = res; tick();
      alu_done = 1'b0; alu_result = W'($urandom);
    end

    k = 0;
    while (busy && k < 200) begin
      maybe_toggle(tgl);
      tick();
      k++;
    end
    check("operation_completes", busy, 0);
    active = 1'b0;
    if (!err && gap == 0) check("start_to_first_out_latency", first_ov_cyc - st, OPW + 2*W + n + 2);
    if (err) check("error_sticky_in_idle", error, 1);
    tick();
  endtask

  initial begin
    int r;
    int n;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_outputs", {op_code, operand_a, operand_b, alu_start, out_bit, out_valid, done}, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Abort mid-LOAD_A: op bits 0,1 then one A bit, then reset.
    mode = 1'b0; active = 1'b1; tick();
    valid_data = 1'b1; data_bit = 1'b0; tick();
    data_bit = 1'b1; tick();
    data_bit = 1'b1; tick();
    check("busy_mid_load", busy, 1);
    valid_data = 1'b0; active = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_outputs", {op_code, operand_a, operand_b, alu_start, out_bit, out_valid, done, error}, 0);
    tick();
    check("abort_stays_idle", busy, 0);

    run_txn(1'b0, 2'b01, 4'hA, 4'h3, 0, 2, 4'hD, 1'b0);
    run_txn(1'b1, 2'b01, 4'hA, 4'h3, 0, 3, 4'h6, 1'b0);
    run_txn(1'b0, 2'b01, 4'hA, 4'h3, 3, 2, 4'hD, 1'b0);
    run_txn(1'b1, 2'b10, 4'h5, 4'hC, 0, 0, 4'h9, 1'b0);
    run_txn(1'b0, 2'b11, 4'h7, 4'h8, 0, 1, 4'hE, 1'b0);
    run_txn(1'b0, 2'b10, 4'h9, 4'h4, 0, 4, 4'hB, 1'b1);
    run_txn(1'b1, 2'b00, 4'hF, 4'h1, 1, -1, 4'h5, 1'b1);
    run_txn(1'b0, 2'b01, 4'h2, 4'hE, 0, TO, 4'h3, 1'b0);
    run_txn(1'b1, 2'b11, 4'h6, 4'h6, 0, TO + 1, 4'hA, 1'b0);

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 19);
      n = (r == 0) ? 0 : (r == 1) ? -1 : r - 1;
      run_txn(1'($urandom_range(0, 1)), OPW'($urandom), W'($urandom), W'($urandom),
              $urandom_range(0, 2), n, W'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    check("exec_queue_drained", exec_q.size(), 0);
    check("bit_queue_drained", bit_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
